midi_msg_parser: RTL and testbench

- Converts the raw MIDI byte stream from the UART receiver into the single-cycle note event strobes and fields consumed by the synth voice controller.
- Handles running status, note-on with velocity 0, real-time byte interleaving, SysEx discard, and a debug read-back trigger.
- Sits between the UART RX block and synth2, in the clk32 domain.

---
 rtl/midi_msg_parser.sv | 79 +++++++
 tb/tb_midi_msg_parser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: MIDI byte stream to registered note-event strobes and fields.
// clk32/rst: 32 MHz clock, synchronous active-high reset.
// rx_data/rx_valid: received byte and its one-cycle strobe.
// note_pressed/note_released/note_keypress/note_channelpress/read_back: one-cycle event strobes.
// note_interface/velocity/channel: fields of the last event; err_count: saturating orphan data byte count.
module midi_msg_parser #(
  parameter logic [6:0] RB_CONTROLLER = 7'h7F
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic       note_channelpress,
  output logic       read_back,
  output logic [6:0] note_interface,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {S_IDLE, S_D1, S_D2, S_SYSEX} state_t;
  state_t state, state_n;
  logic [7:0] status, status_n;
  logic [6:0] d1, d1_n;
  logic done, orphan, press, rel, key, chp, rb;
  logic [3:0] hi;
  assign hi = status[7:4];
  always_comb begin
    state_n = state;
    status_n = status;
    d1_n = d1;
    done = 1'b0;
    orphan = 1'b0;
    if (rx_valid && rx_data[7:3] != 5'h1F) begin
      if (rx_data[7] && rx_data[7:4] != 4'hF) begin
        status_n = rx_data;
        state_n = S_D1;
      end else if (rx_data[7]) begin
        status_n = 8'h00;
        state_n = (rx_data == 8'hF0 && state != S_SYSEX) ? S_SYSEX : S_IDLE;
      end else begin
        orphan = state == S_IDLE;
        done = state == S_D2 || (state == S_D1 && (hi == 4'hC || hi == 4'hD));
        d1_n = (state == S_D1) ? rx_data[6:0] : d1;
        state_n = (state == S_D1 && !done) ? S_D2 : (state == S_D2) ? S_D1 : state;
      end
    end
  end
  assign press = done && hi == 4'h9 && rx_data[6:0] != 7'h00;
  assign rel = done && (hi == 4'h8 || (hi == 4'h9 && rx_data[6:0] == 7'h00));
  assign key = done && hi == 4'hA;
  assign chp = done && hi == 4'hD;
  assign rb = done && hi == 4'hB && d1 == RB_CONTROLLER;
  always_ff @(posedge clk32) begin
    if (rst) begin
      state <= S_IDLE;
      status <= 8'h00;
      d1 <= 7'h00;
      {note_pressed, note_released, note_keypress, note_channelpress, read_back} <= 5'b0;
      note_interface <= 7'h00;
      velocity <= 7'h00;
      channel <= 4'h0;
      err_count <= 8'h00;
    end else begin
      state <= state_n;
      status <= status_n;
      d1 <= d1_n;
      {note_pressed, note_released, note_keypress, note_channelpress, read_back} <= {press, rel, key, chp, rb};
      if (press || key || (rel && hi == 4'h8)) note_interface <= d1;
      if (press || rel || key || chp || rb) begin
        velocity <= rx_data[6:0];
        channel <= status[3:0];
      end
      if (orphan && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
  end
endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: directed and randomized checks of midi_msg_parser against a message-level model.
module tb_midi_msg_parser;
  logic clk32 = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic note_pressed, note_released, note_keypress, note_channelpress, read_back;
  logic [6:0] note_interface, velocity;
  logic [3:0] channel;
  logic [7:0] err_count;
  int checks = 0, fails = 0;
  logic [7:0] m_rs = 8'h00;
  logic [6:0] m_d[$];
  bit m_sx = 1'b0;
  logic [4:0] m_str = 5'b0;
  logic [6:0] m_note = 7'h00, m_vel = 7'h00;
  logic [3:0] m_ch = 4'h0;
  logic [7:0] m_err = 8'h00;
  wire [30:0] obs = {note_pressed, note_released, note_keypress, note_channelpress, read_back,
                     note_interface, velocity, channel, err_count};

  midi_msg_parser dut (
    .clk32(clk32), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_pressed(note_pressed), .note_released(note_released), .note_keypress(note_keypress),
    .note_channelpress(note_channelpress), .read_back(read_back),
    .note_interface(note_interface), .velocity(velocity), .channel(channel), .err_count(err_count)
  );

  always #5 clk32 = ~clk32;

  function automatic logic [30:0] exp_v();
    return {m_str, m_note, m_vel, m_ch, m_err};
  endfunction

  task automatic complete();
    logic [6:0] a, c;
    a = m_d[0];
    c = m_d[m_d.size() - 1];
    case (m_rs[7:4])
      4'h8: begin m_str = 5'b01000; m_note = a; m_vel = c; end
      4'h9: if (c == 7'h00) begin m_str = 5'b01000; m_vel = 7'h00; end
            else begin m_str = 5'b10000; m_note = a; m_vel = c; end
      4'hA: begin m_str = 5'b00100; m_note = a; m_vel = c; end
      4'hD: begin m_str = 5'b00010; m_vel = a; end
      4'hB: if (a == 7'h7F) begin m_str = 5'b00001; m_vel = c; end
      default: ;
    endcase
    if (m_str != 5'b0) m_ch = m_rs[3:0];
  endtask

  task automatic model(input logic [7:0] b, input bit v, input bit r);
    int need;
    m_str = 5'b0;
    if (r) begin
      m_rs = 8'h00; m_d.delete(); m_sx = 1'b0;
      m_note = 7'h00; m_vel = 7'h00; m_ch = 4'h0; m_err = 8'h00;
    end else if (v && b < 8'hF8) begin
      if (b >= 8'h80 && b < 8'hF0) begin
        m_rs = b; m_d.delete(); m_sx = 1'b0;
      end else if (b >= 8'hF0) begin
        m_rs = 8'h00; m_d.delete(); m_sx = (b == 8'hF0) && !m_sx;
      end else if (!m_sx) begin
        if (m_rs == 8'h00) begin
          if (m_err != 8'hFF) m_err++;
        end else begin
          m_d.push_back(b[6:0]);
          need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
          if (m_d.size() == need) begin
            complete();
            m_d.delete();
          end
        end
      end
    end
  endtask

  task automatic step(input logic [7:0] b, input bit v = 1'b1, input bit r = 1'b0);
    @(negedge clk32);
    rx_data = b; rx_valid = v; rst = r;
    @(posedge clk32);
    model(b, v, r);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(99);
    if (k < 45) return 8'($urandom_range(127));
    if (k < 52) return 8'h7F;
    if (k < 78) return 8'($urandom_range(8'hEF, 8'h80));
    if (k < 86) return 8'($urandom_range(8'hFF, 8'hF8));
    if (k < 90) return 8'hF0;
    if (k < 95) return 8'hF7;
    return 8'($urandom_range(8'hF6, 8'hF1));
  endfunction

  task automatic test_reset();
    step(8'h90, 1'b1, 1'b1);
    if (obs !== 31'h0) begin fails++; $display("FAIL reset: got %h want %h", obs, 31'h0); end
    checks++;
  endtask

  task automatic test_note_on();
    logic [7:0] s[3] = '{8'h90, 8'h3C, 8'h64};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v()) begin fails++; $display("FAIL note_on byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
    end
    if (obs !== {5'b10000, 7'h3C, 7'h64, 4'h0, 8'h00}) begin fails++; $display("FAIL note_on_fields: got %h", obs); end
    checks++;
    step(8'h00, 1'b0);
    if (obs[30:26] !== 5'b0 || obs[25:0] !== {7'h3C, 7'h64, 4'h0, 8'h00}) begin fails++; $display("FAIL note_on_hold: got %h", obs); end
    checks++;
  endtask

  task automatic test_running_status();
    logic [7:0] s[5] = '{8'h93, 8'h40, 8'h7F, 8'h40, 8'h00};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v()) begin fails++; $display("FAIL running byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
      if (i == 2 && obs !== {5'b10000, 7'h40, 7'h7F, 4'h3, 8'h00}) begin fails++; $display("FAIL running_press: got %h", obs); end
      if (i == 3 && obs[30:26] !== 5'b0) begin fails++; $display("FAIL running_gap: got %h", obs); end
      if (i == 4 && obs !== {5'b01000, 7'h40, 7'h00, 4'h3, 8'h00}) begin fails++; $display("FAIL running_release: got %h", obs); end
      if (i >= 2) checks++;
    end
  endtask

  task automatic test_realtime();
    logic [7:0] s[4] = '{8'h90, 8'h3C, 8'hF8, 8'h64};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v()) begin fails++; $display("FAIL realtime byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
    end
    if (obs !== {5'b10000, 7'h3C, 7'h64, 4'h0, 8'h00}) begin fails++; $display("FAIL realtime_fields: got %h", obs); end
    checks++;
  endtask

  task automatic test_sysex();
    logic [7:0] s[7] = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'hF7, 8'h3C, 8'h64};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v() || obs[30:26] !== 5'b0) begin fails++; $display("FAIL sysex byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
    end
    if (err_count !== 8'd2) begin fails++; $display("FAIL sysex_err: got %h want 02", err_count); end
    checks++;
  endtask

  task automatic test_read_back();
    logic [7:0] s[6] = '{8'hB5, 8'h7F, 8'h02, 8'hB5, 8'h07, 8'h10};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v()) begin fails++; $display("FAIL read_back byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
      if (i == 2 && obs !== {5'b00001, 7'h00, 7'h02, 4'h5, 8'h00}) begin fails++; $display("FAIL read_back_strobe: got %h", obs); end
      if (i == 5 && obs !== {5'b00000, 7'h00, 7'h02, 4'h5, 8'h00}) begin fails++; $display("FAIL other_cc: got %h", obs); end
      if (i == 2 || i == 5) checks++;
    end
  endtask

  task automatic test_chanpress();
    logic [7:0] s[5] = '{8'hD2, 8'h30, 8'h31, 8'hC0, 8'h05};
    step(8'h00, 1'b0, 1'b1);
    foreach (s[i]) begin
      step(s[i]);
      if (obs !== exp_v()) begin fails++; $display("FAIL chanpress byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
      if (i == 1 && obs !== {5'b00010, 7'h00, 7'h30, 4'h2, 8'h00}) begin fails++; $display("FAIL chanpress_1: got %h", obs); end
      if (i == 2 && obs !== {5'b00010, 7'h00, 7'h31, 4'h2, 8'h00}) begin fails++; $display("FAIL chanpress_2: got %h", obs); end
      if (i == 4 && obs !== {5'b00000, 7'h00, 7'h31, 4'h2, 8'h00}) begin fails++; $display("FAIL progchange: got %h", obs); end
      if (i == 1 || i == 2 || i == 4) checks++;
    end
  endtask

  task automatic test_saturate();
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 258; i++) begin
      step(8'($urandom_range(127)));
      if (obs !== exp_v()) begin fails++; $display("FAIL saturate byte %0d: got %h want %h", i, obs, exp_v()); end
      checks++;
      if (i >= 254 && err_count !== 8'hFF) begin fails++; $display("FAIL saturate_ff %0d: got %h want ff", i, err_count); end
      if (i >= 254) checks++;
    end
  endtask

  task automatic test_back_to_back();
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(rand_byte(), $urandom_range(9) != 0, $urandom_range(299) == 0);
      if (obs !== exp_v()) begin fails++; $display("FAIL random cycle %0d byte %h: got %h want %h", i, rx_data, obs, exp_v()); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_sysex();
    test_read_back();
    test_chanpress();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
